// File: rtl/event_counter_pkg.sv
// Shared constants for the event counter bank: direction and overflow mode encodings.
package event_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : event_counter_pkg

// File: rtl/event_counter_channel.sv
// Single event counter channel: up/down counting between 0 and a runtime
// terminal value, with wrap or saturate behaviour, a one-cycle terminal-count
// pulse and a sticky overflow flag.
module event_counter_channel
    import event_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             down,
    input  logic             sat,
    input  logic [WIDTH-1:0] modulus,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;

    // Next-state: clear beats events; counts above a lowered modulus are
    // handled by >= / > compares so they never walk the full 2^WIDTH range.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf;
        if (clear) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (x) begin
            if (down == DIR_UP) begin
                if (r_count >= modulus) begin
                    w_tc_nxt    = 1'b1;
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = (sat == MODE_SAT) ? modulus : '0;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_tc_nxt    = 1'b1;
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = (sat == MODE_SAT) ? '0 : modulus;
                end else if (r_count > modulus) begin
                    w_count_nxt = modulus;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule : event_counter_channel

// File: rtl/event_counter_bank.sv
// Bank of independent event counters sharing one runtime terminal value and
// one wrap/saturate mode; channel i's count is packed at [i*WIDTH +: WIDTH].
module event_counter_bank #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       x,
    input  logic [CHANNELS-1:0]       down,
    input  logic                      sat,
    input  logic [WIDTH-1:0]          modulus,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    // One counter instance per channel; all outputs are registered inside.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        event_counter_channel #(
            .WIDTH   (WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .x       (x[g]),
            .down    (down[g]),
            .sat     (sat),
            .modulus (modulus),
            .clear   (clear[g]),
            .count   (count[g*WIDTH +: WIDTH]),
            .tc      (tc[g]),
            .ovf     (ovf[g])
        );
    end

endmodule : event_counter_bank

// File: doc/event_counter_bank.md
# event_counter_bank

Parametrised bank of independent event counters with a shared runtime terminal value, per-channel up/down direction, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Each channel counts qualified events on its `x` input and signals when it passes its terminal value. It sits between input event sources (debounced buttons, detector strobes) and the display/control logic, which reads `count` and reacts to `tc`/`ovf`.

## Interface
- Clocking: reset reset, synchronous, active-high; clock clk.
- `WIDTH`, 2: counter width per channel, ≥1.
- `CHANNELS`, 4: number of independent counters, ≥1.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous active-high reset, all channels.
- `x` in CHANNELS: per-channel event qualifier; one event per cycle high.
- `down` in CHANNELS: per-channel direction; 0 = up, 1 = down.
- `sat` in 1: global mode; 0 = wrap, 1 = saturate.
- `modulus` in WIDTH: shared terminal value; each channel counts 0..modulus inclusive.
- `clear` in CHANNELS: per-channel synchronous clear.
- `count` out CHANNELS*WIDTH: channel i at bits [i*WIDTH +: WIDTH].
- `tc` out CHANNELS: terminal-count pulse, one cycle per terminal event.
- `ovf` out CHANNELS: sticky, set on any terminal event, cleared only by `clear`/`reset`.

## Operation
- Per-channel priority: `reset` > `clear[i]` > `x[i]`.
- `reset` or `clear[i]`: count←0, tc←0, ovf←0; pending `x[i]` in that cycle is dropped.
- `x[i]`=0: count holds, tc←0, ovf holds.
- Up, `x[i]`=1, count ≥ modulus (terminal): tc←1, ovf←1; count←0 if sat=0, count←modulus if sat=1.
- Up, `x[i]`=1, count < modulus: count←count+1, tc←0.
- Down, `x[i]`=1, count = 0 (terminal): tc←1, ovf←1; count←modulus if sat=0, holds 0 if sat=1.
- Down, `x[i]`=1, count > modulus (modulus lowered at runtime): count←modulus, tc←0.
- Down, otherwise: count←count−1, tc←0.
- modulus = 0: every event is terminal; count stays 0; tc pulses per event.
- Arithmetic in WIDTH bits, unsigned; the ≥/> comparisons guarantee no wrap through the full 2^WIDTH range when count exceeds modulus.
- `down`, `sat`, `modulus` are sampled on the event cycle only; changes take effect on the next event, never retroactively.
- Channels are fully independent; simultaneous events on all channels all take effect.

## Timing
- Reset values: count = 0, tc = 0, ovf = 0 for every channel.
- All outputs are registered, with no combinational input→output path.
- Latency 1: the edge sampling `x[i]`=1 updates count and tc together. tc is high for exactly the cycle after a terminal event and is re-asserted on back-to-back terminal events, as in sat=1 with `x` held high.
- `ovf` rises with the first tc and stays high until clear/reset.
- Reset mid-count is immediate at the next edge, regardless of `x`.

## Structure
- Package `event_counter_pkg`: `DIR_UP`/`DIR_DOWN` and `MODE_WRAP`/`MODE_SAT` constants.
- Sub-module `event_counter_channel` (WIDTH parameter; ports clk, reset, x, down, sat, modulus, clear, count, tc, ovf) holds the per-channel next-state logic.
- The top generates CHANNELS instances and packs `count`.

## Test plan
- Defaults (WIDTH=2, modulus=3, up, sat=0), 5 events on ch0 -> count 1,2,3,0,1; tc high only in the cycle after the 4th event; ovf=1 thereafter; ch1–3 stay 0.
- modulus=2, sat=1, up, `x` held high 5 cycles -> count 1,2,2,2,2; tc pulses on cycles 3,4,5; ovf=1.
- Down, sat=0, modulus=3, from 0, 2 events -> count 3 with tc=1, then count 2 with tc=0.
- Count ch0 to 3, lower modulus to 1, 1 up event -> count 0, tc=1. In down mode from count 3 with modulus=1, 1 event -> count 1, tc=0.
- `clear[2]` and `x[2]` same cycle while `ovf[2]`=1 -> count 0, tc 0, ovf 0. Other channels counting the same cycle are unaffected.
- `reset` asserted mid-sequence with all `x`=1 -> next cycle all count 0, tc 0, ovf 0. Counting resumes from 0 after reset deasserts.
